// File: rtl/ir_flag_unit.sv
// Instruction register with NZCV flag file and predicate-block tracking.
// Perform is the combinational execute enable for the word currently held in IR.
module ir_flag_unit #(
  parameter int unsigned WIDTH      = 16,
  parameter logic [3:0]  PRED_OP    = 4'hF,
  parameter int unsigned PRED_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             IW,
  input  logic             FU,
  input  logic [WIDTH-1:0] MD,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic             ALUCarry,
  input  logic             ALUOvf,
  output logic [WIDTH-1:0] IR,
  output logic [3:0]       Op,
  output logic [3:0]       Flags,
  output logic             Perform,
  output logic             PredActive,
  output logic [3:0]       PredCount
);

  typedef enum logic [3:0] {
    CC_AL = 4'h0, CC_EQ = 4'h1, CC_NE = 4'h2, CC_CS = 4'h3,
    CC_CC = 4'h4, CC_MI = 4'h5, CC_PL = 4'h6, CC_VS = 4'h7,
    CC_VC = 4'h8, CC_HI = 4'h9, CC_LS = 4'hA, CC_GE = 4'hB,
    CC_LT = 4'hC, CC_GT = 4'hD, CC_LE = 4'hE, CC_NV = 4'hF
  } cond_e;

  localparam logic [3:0] DEPTH4 = 4'(PRED_DEPTH);

  logic [WIDTH-1:0] ir_q,    ir_d;
  logic             valid_q, valid_d;
  logic             n_q, z_q, c_q, v_q;
  logic             n_d, z_d, c_d, v_d;
  logic             pred_q,  pred_d;
  logic [3:0]       pcond_q, pcond_d;
  logic [3:0]       pcnt_q,  pcnt_d;

  logic [3:0]       md_op;
  logic [3:0]       md_len;
  logic [3:0]       md_len_sat;
  logic [3:0]       ir_op;
  logic             cond_ir;
  logic             cond_pred;

  function automatic logic eval_cond(input logic [3:0] c,
                                     input logic n, input logic z,
                                     input logic cf, input logic v);
    logic r;
    r = 1'b0;
    case (cond_e'(c))
      CC_AL: r = 1'b1;
      CC_EQ: r = z;
      CC_NE: r = ~z;
      CC_CS: r = cf;
      CC_CC: r = ~cf;
      CC_MI: r = n;
      CC_PL: r = ~n;
      CC_VS: r = v;
      CC_VC: r = ~v;
      CC_HI: r = cf & ~z;
      CC_LS: r = ~cf | z;
      CC_GE: r = (n == v);
      CC_LT: r = (n != v);
      CC_GT: r = ~z & (n == v);
      CC_LE: r = z | (n != v);
      CC_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign md_op      = MD[WIDTH-1 -: 4];
  assign md_len     = MD[7:4];
  assign md_len_sat = (md_len > DEPTH4) ? DEPTH4 : md_len;

  always_comb begin
    ir_d    = ir_q;
    valid_d = valid_q;
    pred_d  = pred_q;
    pcond_d = pcond_q;
    pcnt_d  = pcnt_q;
    if (IW) begin
      ir_d    = MD;
      valid_d = 1'b1;
      if (md_op == PRED_OP) begin
        // A new predicate word always restarts the block; nesting is not supported.
        pcond_d = MD[3:0];
        pcnt_d  = md_len_sat;
        pred_d  = 1'b0;
      end else if (pcnt_q != '0) begin
        pred_d = 1'b1;
        pcnt_d = pcnt_q - 4'd1;
      end else begin
        pred_d = 1'b0;
      end
    end
  end

  always_comb begin
    n_d = n_q;
    z_d = z_q;
    c_d = c_q;
    v_d = v_q;
    if (FU) begin
      n_d = ALUOut[WIDTH-1];
      z_d = (ALUOut == '0);
      c_d = ALUCarry;
      v_d = ALUOvf;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ir_q    <= '0;
      valid_q <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      pred_q  <= 1'b0;
      pcond_q <= '0;
      pcnt_q  <= '0;
    end else begin
      ir_q    <= ir_d;
      valid_q <= valid_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      pred_q  <= pred_d;
      pcond_q <= pcond_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Both conditions use the live flags so in-block flag updates steer later instructions.
  assign ir_op     = ir_q[WIDTH-1 -: 4];
  assign cond_ir   = eval_cond(ir_q[3:0], n_q, z_q, c_q, v_q);
  assign cond_pred = eval_cond(pcond_q,   n_q, z_q, c_q, v_q);

  always_comb begin
    Perform = 1'b0;
    if (valid_q && (ir_op != PRED_OP)) begin
      Perform = pred_q ? (cond_ir & cond_pred) : cond_ir;
    end
  end

  assign IR         = ir_q;
  assign Op         = ir_op;
  assign Flags      = {n_q, z_q, c_q, v_q};
  assign PredActive = pred_q;
  assign PredCount  = pcnt_q;

endmodule

// File: tb/tb_ir_flag_unit.sv
// Directed bench for ir_flag_unit (WIDTH=16, PRED_DEPTH=4) with hand-computed expectations.
module tb_ir_flag_unit;

  logic        CLK = 1'b0;
  logic        Reset, IW, FU, ALUCarry, ALUOvf;
  logic [15:0] MD, ALUOut;
  logic [15:0] IR;
  logic [3:0]  Op, Flags, PredCount;
  logic        Perform, PredActive;

  int unsigned errors = 0;
  int unsigned checks = 0;

  ir_flag_unit #(.WIDTH(16), .PRED_OP(4'hF), .PRED_DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset), .IW(IW), .FU(FU), .MD(MD), .ALUOut(ALUOut),
    .ALUCarry(ALUCarry), .ALUOvf(ALUOvf), .IR(IR), .Op(Op), .Flags(Flags),
    .Perform(Perform), .PredActive(PredActive), .PredCount(PredCount)
  );

  always #5 CLK = ~CLK;

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic rst, input logic iw, input logic [15:0] md,
                     input logic fu, input logic [15:0] alu,
                     input logic cy, input logic ov);
    @(negedge CLK);
    Reset = rst; IW = iw; MD = md; FU = fu; ALUOut = alu; ALUCarry = cy; ALUOvf = ov;
    @(posedge CLK);
    #1;
    Reset = 1'b0; IW = 1'b0; FU = 1'b0;
  endtask

  task automatic load(input logic [15:0] md);
    cyc(1'b0, 1'b1, md, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic flags(input logic [15:0] alu, input logic cy, input logic ov);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, alu, cy, ov);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({IR, Flags, Op, PredCount, Perform, PredActive} !== 30'h0) begin
      errors++;
      $display("FAIL reset_state: IR=%h Flags=%b Op=%h PC=%0d Perf=%b PA=%b, required all 0",
               IR, Flags, Op, PredCount, Perform, PredActive);
    end
  endtask

  task automatic test_flags_basic();
    do_reset();
    flags(16'h0000, 1'b0, 1'b0);
    load(16'h1001);
    checks++;
    if ({Op, Flags, Perform} !== {4'h1, 4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL eq_taken: Op=%h Flags=%b Perf=%b, required Op=1 Flags=0100 Perf=1", Op, Flags, Perform);
    end
    flags(16'h8000, 1'b0, 1'b0);
    checks++;
    if ({Flags, Perform} !== {4'b1000, 1'b0}) begin
      errors++;
      $display("FAIL eq_not_taken: Flags=%b Perf=%b, required 1000/0", Flags, Perform);
    end
    load(16'h2005);
    checks++;
    if (Perform !== 1'b1) begin
      errors++;
      $display("FAIL mi_taken: Perf=%b, required 1", Perform);
    end
    flags(16'h0001, 1'b1, 1'b1);
    checks++;
    if (Flags !== 4'b0011) begin
      errors++;
      $display("FAIL carry_ovf_flags: Flags=%b, required 0011", Flags);
    end
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checks++;
    if ({IR, Flags} !== {16'h2005, 4'b0011}) begin
      errors++;
      $display("FAIL hold: IR=%h Flags=%b, required 2005/0011", IR, Flags);
    end
  endtask

  // Per flag pattern, bit i of the mask is the expected Perform for condition i.
  task automatic test_cond_table();
    logic [15:0] alu  [4] = '{16'h0000, 16'h0001, 16'h8000, 16'h8000};
    logic        cy   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        ov   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] mask [4] = '{16'h4D53, 16'h2B4D, 16'h2CB5, 16'h532D};
    logic [15:0] m;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      flags(alu[p], cy[p], ov[p]);
      m = mask[p];
      for (int c = 0; c < 16; c++) begin
        load({12'h100, 4'(c)});
        checks++;
        if (Perform !== m[c]) begin
          errors++;
          $display("FAIL cond_table p%0d c%0h: Perf=%b Flags=%b, required %b", p, c, Perform, Flags, m[c]);
        end
      end
    end
  endtask

  task automatic test_pred_block();
    do_reset();
    flags(16'h0000, 1'b0, 1'b0);
    load(16'hF021);
    checks++;
    if ({Perform, PredCount, PredActive} !== {1'b0, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL pred_open: Perf=%b PC=%0d PA=%b, required 0/2/0", Perform, PredCount, PredActive);
    end
    load(16'h3000);
    checks++;
    if ({Perform, PredActive, PredCount} !== {1'b1, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL pred_first: Perf=%b PA=%b PC=%0d, required 1/1/1", Perform, PredActive, PredCount);
    end
    load(16'h4000);
    checks++;
    if ({PredCount, PredActive} !== {4'd0, 1'b1}) begin
      errors++;
      $display("FAIL pred_last: PC=%0d PA=%b, required 0/1", PredCount, PredActive);
    end
    load(16'h5000);
    checks++;
    if ({PredActive, Perform, PredCount} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL pred_closed: PA=%b Perf=%b PC=%0d, required 0/1/0", PredActive, Perform, PredCount);
    end
  endtask

  task automatic test_pred_live_flags();
    do_reset();
    flags(16'h0001, 1'b0, 1'b0);
    load(16'hF011);
    load(16'h3000);
    checks++;
    if ({Perform, PredActive} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL pred_suppressed: Perf=%b PA=%b, required 0/1", Perform, PredActive);
    end
    flags(16'h0000, 1'b0, 1'b0);
    checks++;
    if ({Perform, IR} !== {1'b1, 16'h3000}) begin
      errors++;
      $display("FAIL pred_live_flag: Perf=%b IR=%h, required 1/3000", Perform, IR);
    end
    // Inner condition false even though the predicate holds.
    load(16'hF011);
    load(16'h3002);
    checks++;
    if ({Perform, PredActive} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL pred_and_inner: Perf=%b PA=%b, required 0/1", Perform, PredActive);
    end
  endtask

  task automatic test_pred_count();
    do_reset();
    load(16'hF0F0);
    checks++;
    if (PredCount !== 4'd4) begin
      errors++;
      $display("FAIL pred_saturate: PC=%0d, required 4", PredCount);
    end
    load(16'hF000);
    checks++;
    if (PredCount !== 4'd0) begin
      errors++;
      $display("FAIL pred_zero_len: PC=%0d, required 0", PredCount);
    end
    load(16'h1000);
    checks++;
    if ({PredActive, PredCount, Perform} !== {1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL pred_zero_nopen: PA=%b PC=%0d Perf=%b, required 0/0/1", PredActive, PredCount, Perform);
    end
    load(16'hF021);
    load(16'hF031);
    checks++;
    if ({PredCount, PredActive} !== {4'd3, 1'b0}) begin
      errors++;
      $display("FAIL pred_replace: PC=%0d PA=%b, required 3/0", PredCount, PredActive);
    end
    load(16'hF050);
    checks++;
    if (PredCount !== 4'd4) begin
      errors++;
      $display("FAIL pred_sat_5: PC=%0d, required 4", PredCount);
    end
  endtask

  task automatic test_reset_mid_block();
    do_reset();
    load(16'hF041);
    load(16'h1000);
    checks++;
    if ({PredActive, PredCount} !== {1'b1, 4'd3}) begin
      errors++;
      $display("FAIL mid_block_setup: PA=%b PC=%0d, required 1/3", PredActive, PredCount);
    end
    do_reset();
    checks++;
    if ({PredCount, PredActive, Perform, IR} !== {4'd0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL mid_block_reset: PC=%0d PA=%b Perf=%b IR=%h, required 0/0/0/0000",
               PredCount, PredActive, Perform, IR);
    end
    load(16'h1000);
    checks++;
    if ({Perform, PredActive} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_load: Perf=%b PA=%b, required 1/0", Perform, PredActive);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1'b0, 1'b1, 16'h1001, 1'b1, 16'h0000, 1'b1, 1'b0);
    checks++;
    if ({IR, Flags, Perform} !== {16'h1001, 4'b0110, 1'b1}) begin
      errors++;
      $display("FAIL iw_fu_same_edge: IR=%h Flags=%b Perf=%b, required 1001/0110/1", IR, Flags, Perform);
    end
    cyc(1'b1, 1'b1, 16'h1000, 1'b1, 16'h8000, 1'b1, 1'b1);
    checks++;
    if ({IR, Flags, Perform} !== {16'h0, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_priority: IR=%h Flags=%b Perf=%b, required 0000/0000/0", IR, Flags, Perform);
    end
    load(16'h5000);
    load(16'h6009);
    checks++;
    if ({Op, Perform} !== {4'h6, 1'b0}) begin
      errors++;
      $display("FAIL back_to_back_hi: Op=%h Perf=%b, required 6/0", Op, Perform);
    end
  endtask

  initial begin
    Reset = 1'b0; IW = 1'b0; FU = 1'b0; MD = '0; ALUOut = '0; ALUCarry = 1'b0; ALUOvf = 1'b0;
    test_reset();
    test_flags_basic();
    test_cond_table();
    test_pred_block();
    test_pred_live_flags();
    test_pred_count();
    test_reset_mid_block();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ir_flag_unit.md
IR_FLAG_UNIT -- requirements
Module: ir_flag_unit

Interface
- REQ-001 Parameter WIDTH, default 16, instruction/data width, legal range 12..32.
- REQ-002 Parameter PRED_OP, default 4'hF, opcode value that opens a predicate block.
- REQ-003 Parameter PRED_DEPTH, default 4, maximum predicate block length, legal range 1..15.
- REQ-004 CLK  in  1  single clock; all state updates on rising edge.
- REQ-005 Reset  in  1  synchronous, active-high reset.
- REQ-006 IW  in  1  instruction write; loads MD into IR.
- REQ-007 FU  in  1  flag update; loads flags from ALU inputs.
- REQ-008 MD  in  WIDTH  instruction word from memory data.
- REQ-009 ALUOut  in  WIDTH  ALU result.
- REQ-010 ALUCarry, ALUOvf  in  1 each  ALU carry-out and signed overflow.
- REQ-011 IR  out  WIDTH  instruction register contents.
- REQ-012 Op  out  4  IR[WIDTH-1:WIDTH-4].
- REQ-013 Flags  out  4  {N,Z,C,V}.
- REQ-014 Perform  out  1  execute enable for the instruction currently in IR.
- REQ-015 PredActive  out  1  IR instruction lies inside a predicate block.
- REQ-016 PredCount  out  4  remaining predicate block length.

Function
- REQ-017 IW=1 SHALL load IR<=MD and set valid<=1 at the next edge; IW=0 SHALL hold IR.
- REQ-018 FU=1 SHALL load Z<=(ALUOut==0), N<=ALUOut[WIDTH-1], C<=ALUCarry, V<=ALUOvf; FU=0 SHALL hold all flags.
- REQ-019 IW and FU asserted together SHALL both take effect at the same edge.
- REQ-020 The condition field SHALL be IR[3:0], encoded as: 0 AL, 1 EQ(Z), 2 NE, 3 CS(C), 4 CC, 5 MI(N), 6 PL, 7 VS(V), 8 VC, 9 HI(C&~Z), A LS, B GE(N==V), C LT, D GT(~Z&N==V), E LE, F NV (never).
- REQ-021 Perform SHALL be combinational from registered IR, flags and predicate state, with no extra latency: a word loaded at edge k SHALL drive Perform immediately after edge k using the flags present after edge k.
- REQ-022 Perform SHALL be 0 while valid=0 and 0 while Op==PRED_OP.
- REQ-023 Otherwise Perform SHALL equal eval(IR[3:0]) when pred_q=0, and eval(IR[3:0]) AND eval(pcond) when pred_q=1; both conditions SHALL use the live flags.
- REQ-024 An IW load with MD opcode==PRED_OP SHALL set pcond<=MD[3:0], PredCount<=min(MD[7:4],PRED_DEPTH) and pred_q<=0.
- REQ-025 A PRED_OP load with MD[7:4]==0 SHALL leave PredCount=0, so no block is opened.
- REQ-026 An IW load of any other opcode while PredCount>0 SHALL set pred_q<=1 and PredCount<=PredCount-1.
- REQ-027 An IW load of any other opcode while PredCount==0 SHALL set pred_q<=0.
- REQ-028 PredCount SHALL never wrap below 0 or exceed PRED_DEPTH.
- REQ-029 A PRED_OP load inside an open block SHALL replace pcond and PredCount; blocks SHALL NOT nest.
- REQ-030 PredActive SHALL equal pred_q.
- REQ-031 Flag updates inside a block SHALL affect later predicated instructions, because flags are evaluated live per REQ-023.

Reset
- REQ-032 Reset SHALL clear IR to 0, flags to 0, valid to 0, pred_q to 0, pcond to 0 and PredCount to 0, so Perform=0, PredActive=0 and Op=0.
- REQ-033 Reset SHALL take priority over simultaneous IW and FU.
- REQ-034 Reset asserted mid-block SHALL abandon the block.

Verification (WIDTH=16, PRED_DEPTH=4)
- REQ-035 Reset; FU with ALUOut=16'h0000; IW with MD=16'h1001 -> Op=1, Z=1, Perform=1.
- REQ-036 FU with ALUOut=16'h8000, IR holding cond EQ -> Flags N=1 Z=0, Perform=0; then IW with MD=16'h2005 -> Perform=1.
- REQ-037 Z=1; IW with MD=16'hF021 -> Perform=0, PredCount=2; IW 16'h3000 -> Perform=1, PredActive=1, PredCount=1; IW 16'h4000 -> PredCount=0, PredActive=1; IW 16'h5000 -> PredActive=0, Perform=1.
- REQ-038 Z=0; IW with MD=16'hF011; IW 16'h3000 -> Perform=0; then FU with ALUOut=0 on the next cycle -> Perform=1 without reloading IR.
- REQ-039 IW with MD=16'hF0F0 -> PredCount=4 (saturated); IW with MD=16'hF000 -> PredCount=0; IW with MD=16'hF031 after IW with MD=16'hF021 -> PredCount=3.
- REQ-040 Reset after IW with MD=16'hF041 and one predicated load -> PredCount=0, PredActive=0, Perform=0, IR=0; a following IW with MD=16'h1000 -> Perform=1.
